// File: rtl/tlp_rx_hdr_parser_if.sv
// Bundles for the RX header parser: inbound DW stream and the decoded header record.
interface tlp_dw_stream_if;
  logic [31:0] in_dw;
  logic        in_valid;
  logic        in_sop;
  logic        in_eop;
  logic        in_ready;

  modport master (output in_dw, in_valid, in_sop, in_eop, input in_ready);
  modport slave  (input in_dw, in_valid, in_sop, in_eop, output in_ready);
endinterface

interface tlp_hdr_rec_if;
  logic        hdr_valid;
  logic        hdr_ready;
  logic [2:0]  hdr_fmt;
  logic [4:0]  hdr_type;
  logic [2:0]  hdr_tc;
  logic [2:0]  hdr_attr;
  logic        hdr_th;
  logic        hdr_td;
  logic        hdr_ep;
  logic [1:0]  hdr_at;
  logic [9:0]  hdr_length;
  logic [7:0]  hdr_req_bus;
  logic [4:0]  hdr_req_dev;
  logic [7:0]  hdr_req_fn;
  logic [9:0]  hdr_tag;
  logic [3:0]  hdr_last_be;
  logic [3:0]  hdr_first_be;
  logic [63:0] hdr_addr;
  logic        hdr_is_4dw;
  logic        err_tag;
  logic        err_malformed;
  logic        err_len;

  modport master (
    output hdr_valid, hdr_fmt, hdr_type, hdr_tc, hdr_attr, hdr_th, hdr_td, hdr_ep, hdr_at,
           hdr_length, hdr_req_bus, hdr_req_dev, hdr_req_fn, hdr_tag, hdr_last_be,
           hdr_first_be, hdr_addr, hdr_is_4dw, err_tag, err_malformed, err_len,
    input  hdr_ready
  );
  modport slave (
    input  hdr_valid, hdr_fmt, hdr_type, hdr_tc, hdr_attr, hdr_th, hdr_td, hdr_ep, hdr_at,
           hdr_length, hdr_req_bus, hdr_req_dev, hdr_req_fn, hdr_tag, hdr_last_be,
           hdr_first_be, hdr_addr, hdr_is_4dw, err_tag, err_malformed, err_len,
    output hdr_ready
  );
endinterface

// File: rtl/tlp_rx_hdr_parser.sv
// RX TLP header parser: collects a 3DW/4DW header from a DW stream, presents a registered
// decoded record, and polices tag width, header truncation and payload length.
module tlp_rx_hdr_parser #(
  parameter int SUPPORT_10BIT_TAG = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ari_enabled,
  tlp_dw_stream_if.slave s,
  tlp_hdr_rec_if.master  h
);

  typedef enum logic [2:0] {S_IDLE, S_H1, S_H2, S_H3, S_OUT, S_DRAIN} state_e;

  localparam logic [2:0]  FMT_PREFIX = 3'b100;
  localparam logic [10:0] CNT_MAX    = 11'h7FF;

  state_e      state_q, state_d;
  logic [31:0] dw0_q, dw1_q, dw2_q;
  logic        rdy_en_q, drain_q, chk_q;
  logic [10:0] cnt_q, exp_q, cnt_inc, exp_len;
  logic        mal_q, lenerr_q;

  logic        acc, sop_go, ld_dw1, ld_dw2, fin, mal_d, len_d, drain_enter;
  logic        is4, has_pl;

  logic        hdr_valid_q;
  logic [2:0]  fmt_q, tc_q, attr_q;
  logic [4:0]  type_q, dev_q;
  logic        th_q, td_q, ep_q, is4_q, errtag_q;
  logic [1:0]  at_q;
  logic [9:0]  rec_len_q, tag_q;
  logic [7:0]  bus_q, fn_q;
  logic [3:0]  lbe_q, fbe_q;
  logic [63:0] addr_q;

  logic        unused_ln;
  assign unused_ln = dw0_q[17];

  assign acc     = s.in_valid && s.in_ready;
  assign is4     = dw0_q[29];
  assign has_pl  = dw0_q[30];
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 11'd1;
  assign exp_len = !has_pl ? 11'd0 :
                   (dw0_q[9:0] == 10'd0) ? 11'd1024 : {1'b0, dw0_q[9:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    sop_go  = 1'b0;
    ld_dw1  = 1'b0;
    ld_dw2  = 1'b0;
    fin     = 1'b0;
    mal_d   = 1'b0;
    len_d   = 1'b0;
    case (state_q)
      S_IDLE: if (acc && s.in_sop) sop_go = 1'b1;
      S_H1: if (acc) begin
        if (s.in_sop)      begin mal_d = 1'b1; sop_go = 1'b1; end
        else if (s.in_eop) begin mal_d = 1'b1; state_d = S_IDLE; end
        else               begin ld_dw1 = 1'b1; state_d = S_H2; end
      end
      S_H2: if (acc) begin
        if (s.in_sop)      begin mal_d = 1'b1; sop_go = 1'b1; end
        else if (!is4)     begin fin = 1'b1; state_d = S_OUT; end
        else if (s.in_eop) begin mal_d = 1'b1; state_d = S_IDLE; end
        else               begin ld_dw2 = 1'b1; state_d = S_H3; end
      end
      S_H3: if (acc) begin
        if (s.in_sop) begin mal_d = 1'b1; sop_go = 1'b1; end
        else          begin fin = 1'b1; state_d = S_OUT; end
      end
      S_OUT: if (h.hdr_ready) state_d = drain_q ? S_DRAIN : S_IDLE;
      S_DRAIN: if (acc) begin
        if (s.in_sop)      begin len_d = 1'b1; sop_go = 1'b1; end
        else if (s.in_eop) begin len_d = chk_q && (cnt_inc != exp_q); state_d = S_IDLE; end
      end
      default: state_d = S_IDLE;
    endcase
    // Payload sent with eop on the last header DW is short by definition
    if (fin && has_pl && s.in_eop) len_d = 1'b1;
    // Every accepted sop restarts as DW0; prefixes and one-DW TLPs are malformed
    if (sop_go) begin
      if (s.in_dw[31:29] == FMT_PREFIX) begin
        mal_d   = 1'b1;
        state_d = s.in_eop ? S_IDLE : S_DRAIN;
      end else if (s.in_eop) begin
        mal_d   = 1'b1;
        state_d = S_IDLE;
      end else begin
        state_d = S_H1;
      end
    end
    drain_enter = (state_d == S_DRAIN) && ((state_q != S_DRAIN) || sop_go);
  end

  always_comb begin
    s.in_ready = rdy_en_q && (state_q != S_OUT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdy_en_q <= 1'b0;
      dw0_q    <= '0;
      dw1_q    <= '0;
      dw2_q    <= '0;
      drain_q  <= 1'b0;
      chk_q    <= 1'b0;
      cnt_q    <= '0;
      exp_q    <= '0;
      mal_q    <= 1'b0;
      lenerr_q <= 1'b0;
    end else begin
      rdy_en_q <= 1'b1;
      mal_q    <= mal_d;
      lenerr_q <= len_d;
      if (sop_go) dw0_q <= s.in_dw;
      if (ld_dw1) dw1_q <= s.in_dw;
      if (ld_dw2) dw2_q <= s.in_dw;
      if (fin) begin
        drain_q <= !s.in_eop;
        exp_q   <= exp_len;
      end
      // Length is only policed when the drain follows a decoded header
      if (drain_enter) begin
        cnt_q <= '0;
        chk_q <= (state_q == S_OUT);
      end else if ((state_q == S_DRAIN) && acc) begin
        cnt_q <= cnt_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hdr_valid_q <= 1'b0;
      fmt_q <= '0; type_q <= '0; tc_q <= '0; attr_q <= '0;
      th_q <= 1'b0; td_q <= 1'b0; ep_q <= 1'b0; at_q <= '0; rec_len_q <= '0;
      bus_q <= '0; dev_q <= '0; fn_q <= '0; tag_q <= '0; lbe_q <= '0; fbe_q <= '0;
      addr_q <= '0; is4_q <= 1'b0; errtag_q <= 1'b0;
    end else if (fin) begin
      hdr_valid_q <= 1'b1;
      fmt_q     <= dw0_q[31:29];
      type_q    <= dw0_q[28:24];
      tc_q      <= dw0_q[22:20];
      attr_q    <= {dw0_q[18], dw0_q[13:12]};
      th_q      <= dw0_q[16];
      td_q      <= dw0_q[15];
      ep_q      <= dw0_q[14];
      at_q      <= dw0_q[11:10];
      rec_len_q <= dw0_q[9:0];
      bus_q     <= dw1_q[31:24];
      dev_q     <= ari_enabled ? 5'd0 : dw1_q[23:19];
      fn_q      <= ari_enabled ? dw1_q[23:16] : {5'd0, dw1_q[18:16]};
      tag_q     <= {(SUPPORT_10BIT_TAG != 0) ? {dw0_q[23], dw0_q[19]} : 2'b00, dw1_q[15:8]};
      lbe_q     <= dw1_q[7:4];
      fbe_q     <= dw1_q[3:0];
      addr_q    <= is4 ? {dw2_q, s.in_dw[31:2], 2'b00} : {32'd0, s.in_dw[31:2], 2'b00};
      is4_q     <= is4;
      errtag_q  <= (SUPPORT_10BIT_TAG == 0) && (dw0_q[23] || dw0_q[19]);
    end else if ((state_q == S_OUT) && h.hdr_ready) begin
      hdr_valid_q <= 1'b0;
    end
  end

  assign h.hdr_valid     = hdr_valid_q;
  assign h.hdr_fmt       = fmt_q;
  assign h.hdr_type      = type_q;
  assign h.hdr_tc        = tc_q;
  assign h.hdr_attr      = attr_q;
  assign h.hdr_th        = th_q;
  assign h.hdr_td        = td_q;
  assign h.hdr_ep        = ep_q;
  assign h.hdr_at        = at_q;
  assign h.hdr_length    = rec_len_q;
  assign h.hdr_req_bus   = bus_q;
  assign h.hdr_req_dev   = dev_q;
  assign h.hdr_req_fn    = fn_q;
  assign h.hdr_tag       = tag_q;
  assign h.hdr_last_be   = lbe_q;
  assign h.hdr_first_be  = fbe_q;
  assign h.hdr_addr      = addr_q;
  assign h.hdr_is_4dw    = is4_q;
  assign h.err_tag       = errtag_q;
  assign h.err_malformed = mal_q;
  assign h.err_len       = lenerr_q;

endmodule

// File: tb/tb_tlp_rx_hdr_parser.sv
// Directed bench for tlp_rx_hdr_parser: two instances (8-bit and 10-bit tag) share one stream
// and are checked every cycle against a TLP-level reference model.
module tb_tlp_rx_hdr_parser;

  typedef struct packed {
    logic [2:0]  fmt;
    logic [4:0]  typ;
    logic [2:0]  tc;
    logic [2:0]  attr;
    logic        th;
    logic        td;
    logic        ep;
    logic [1:0]  at;
    logic [9:0]  len;
    logic [7:0]  bus;
    logic [4:0]  dev;
    logic [7:0]  fn;
    logic [9:0]  tag;
    logic [3:0]  lbe;
    logic [3:0]  fbe;
    logic [63:0] addr;
    logic        is4;
    logic        err_tag;
  } rec_t;

  logic clk = 1'b0;
  logic rst;
  logic ari;
  int   vectors = 0;
  int   errors  = 0;
  int   n_mal = 0, n_len = 0, exp_mal = 0, exp_len = 0;
  rec_t q0[$];
  rec_t q1[$];
  rec_t a0, a1;
  logic [31:0] tlp [0:1279];

  always #5 clk = ~clk;

  tlp_dw_stream_if s0();
  tlp_dw_stream_if s1();
  tlp_hdr_rec_if   h0();
  tlp_hdr_rec_if   h1();

  assign s1.in_dw    = s0.in_dw;
  assign s1.in_valid = s0.in_valid;
  assign s1.in_sop   = s0.in_sop;
  assign s1.in_eop   = s0.in_eop;
  assign h1.hdr_ready = h0.hdr_ready;

  tlp_rx_hdr_parser #(.SUPPORT_10BIT_TAG(0)) dut0 (.clk(clk), .rst(rst), .ari_enabled(ari), .s(s0), .h(h0));
  tlp_rx_hdr_parser #(.SUPPORT_10BIT_TAG(1)) dut1 (.clk(clk), .rst(rst), .ari_enabled(ari), .s(s1), .h(h1));

  assign a0 = {h0.hdr_fmt, h0.hdr_type, h0.hdr_tc, h0.hdr_attr, h0.hdr_th, h0.hdr_td, h0.hdr_ep,
               h0.hdr_at, h0.hdr_length, h0.hdr_req_bus, h0.hdr_req_dev, h0.hdr_req_fn, h0.hdr_tag,
               h0.hdr_last_be, h0.hdr_first_be, h0.hdr_addr, h0.hdr_is_4dw, h0.err_tag};
  assign a1 = {h1.hdr_fmt, h1.hdr_type, h1.hdr_tc, h1.hdr_attr, h1.hdr_th, h1.hdr_td, h1.hdr_ep,
               h1.hdr_at, h1.hdr_length, h1.hdr_req_bus, h1.hdr_req_dev, h1.hdr_req_fn, h1.hdr_tag,
               h1.hdr_last_be, h1.hdr_first_be, h1.hdr_addr, h1.hdr_is_4dw, h1.err_tag};

  // Reference decode of a whole header, straight from the field definitions.
  function automatic rec_t model_rec(input logic [31:0] w0, input logic [31:0] w1,
                                     input logic [31:0] w2, input logic [31:0] w3,
                                     input bit use_ari, input bit sup10);
    rec_t r;
    logic [7:0] rid_lo;
    logic [1:0] thi;
    r = '0;
    r.fmt  = w0[31:29];
    r.typ  = w0[28:24];
    r.tc   = w0[22:20];
    r.attr = {w0[18], w0[13:12]};
    r.th   = w0[16];
    r.td   = w0[15];
    r.ep   = w0[14];
    r.at   = w0[11:10];
    r.len  = w0[9:0];
    r.bus  = w1[31:24];
    rid_lo = w1[23:16];
    r.dev  = use_ari ? 5'd0 : 5'(rid_lo / 8);
    r.fn   = use_ari ? rid_lo : (rid_lo % 8);
    thi    = {w0[23], w0[19]};
    r.tag  = sup10 ? {thi, w1[15:8]} : {2'b00, w1[15:8]};
    r.err_tag = !sup10 && (thi != 2'b00);
    r.lbe  = w1[7:4];
    r.fbe  = w1[3:0];
    r.is4  = w0[29];
    r.addr = (r.is4 ? {w2, w3} : {32'd0, w2}) & ~64'd3;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  task automatic chk_errs(input string nm);
    chk({nm, "_malformed_cnt"}, 64'(n_mal), 64'(exp_mal));
    chk({nm, "_len_cnt"}, 64'(n_len), 64'(exp_len));
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic put_dw(input logic [31:0] d, input bit sop, input bit eop);
    int t;
    s0.in_dw = d; s0.in_sop = sop; s0.in_eop = eop; s0.in_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (s0.in_ready !== 1'b1 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) begin
      vectors++; errors++;
      $display("FAIL in_ready_timeout got=0 want=1 dw=%h", d);
    end else begin
      @(posedge clk);
      #1;
    end
    s0.in_valid = 1'b0; s0.in_sop = 1'b0; s0.in_eop = 1'b0;
  endtask

  task automatic expect_rec(input logic [31:0] w0, input logic [31:0] w1,
                            input logic [31:0] w2, input logic [31:0] w3);
    q0.push_back(model_rec(w0, w1, w2, w3, ari, 1'b0));
    q1.push_back(model_rec(w0, w1, w2, w3, ari, 1'b1));
  endtask

  task automatic send_tlp(input int n);
    int hs, want;
    hs = tlp[0][29] ? 4 : 3;
    expect_rec(tlp[0], tlp[1], tlp[2], tlp[3]);
    if (tlp[0][30]) begin
      want = (tlp[0][9:0] == 10'd0) ? 1024 : int'(tlp[0][9:0]);
      if (n - hs != want) exp_len++;
    end else if (n != hs) begin
      exp_len++;
    end
    for (int i = 0; i < n; i++) put_dw(tlp[i], i == 0, i == n - 1);
  endtask

  task automatic set4(input logic [31:0] w0, input logic [31:0] w1,
                      input logic [31:0] w2, input logic [31:0] w3);
    tlp[0] = w0; tlp[1] = w1; tlp[2] = w2; tlp[3] = w3;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      vectors++;
      if (a0 !== '0 || a1 !== '0 || h0.hdr_valid !== 1'b0 || h1.hdr_valid !== 1'b0 ||
          h0.err_malformed !== 1'b0 || h0.err_len !== 1'b0 || h1.err_malformed !== 1'b0 ||
          h1.err_len !== 1'b0 || s0.in_ready !== 1'b0 || s1.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs got rec=%h v=%b rdy=%b want all zero", a0, h0.hdr_valid, s0.in_ready);
      end
    end else begin
      if (h0.hdr_valid === 1'b1) begin
        vectors++;
        if (q0.size() == 0) begin
          errors++;
          $display("FAIL rec0_unexpected got=%h want=no record", a0);
        end else if (a0 !== q0[0]) begin
          errors++;
          $display("FAIL rec0 got=%h want=%h", a0, q0[0]);
        end
      end
      if (h1.hdr_valid === 1'b1) begin
        vectors++;
        if (q1.size() == 0) begin
          errors++;
          $display("FAIL rec1_unexpected got=%h want=no record", a1);
        end else if (a1 !== q1[0]) begin
          errors++;
          $display("FAIL rec1 got=%h want=%h", a1, q1[0]);
        end
      end
      if (h0.hdr_valid === 1'b1 && h0.hdr_ready === 1'b1 && q0.size() > 0) void'(q0.pop_front());
      if (h1.hdr_valid === 1'b1 && h1.hdr_ready === 1'b1 && q1.size() > 0) void'(q1.pop_front());
      if (h0.err_malformed === 1'b1) n_mal++;
      if (h0.err_len === 1'b1) n_len++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rec_t m;
    rst = 1'b0; ari = 1'b0; h0.hdr_ready = 1'b1;
    s0.in_dw = '0; s0.in_valid = 1'b0; s0.in_sop = 1'b0; s0.in_eop = 1'b0;
    idle(3);
    chk("ready_in_reset", 64'(s0.in_ready), 64'd0);
    #2 rst = 1'b1;
    idle(2);
    chk("ready_after_reset", 64'(s0.in_ready), 64'd1);

    // 3DW MRd, non-ARI: pin the model and the DUT against hand values
    m = model_rec(32'h0000_0001, 32'h0123_0A0F, 32'h1000_0004, 32'h0, 1'b0, 1'b0);
    chk("model_addr", m.addr, 64'h1000_0004);
    chk("model_dev", 64'(m.dev), 64'd4);
    chk("model_fn", 64'(m.fn), 64'd3);
    set4(32'h0000_0001, 32'h0123_0A0F, 32'h1000_0004, 32'h0);
    send_tlp(3);
    chk("mrd_valid_lat", 64'(h0.hdr_valid), 64'd1);
    chk("mrd_addr", h0.hdr_addr, 64'h1000_0004);
    chk("mrd_bus", 64'(h0.hdr_req_bus), 64'h01);
    chk("mrd_dev", 64'(h0.hdr_req_dev), 64'd4);
    chk("mrd_fn", 64'(h0.hdr_req_fn), 64'd3);
    chk("mrd_tag", 64'(h0.hdr_tag), 64'h0A);
    chk("mrd_len", 64'(h0.hdr_length), 64'd1);
    idle(3);
    chk_errs("mrd");

    // ARI form with downstream stall
    ari = 1'b1; h0.hdr_ready = 1'b0;
    send_tlp(3);
    chk("ari_valid", 64'(h0.hdr_valid), 64'd1);
    chk("ari_fn", 64'(h0.hdr_req_fn), 64'h23);
    chk("ari_dev", 64'(h0.hdr_req_dev), 64'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_in_ready", 64'(s0.in_ready), 64'd0);
      chk("stall_valid", 64'(h0.hdr_valid), 64'd1);
    end
    @(posedge clk); #1;
    h0.hdr_ready = 1'b1;
    idle(2);
    chk("ari_released", 64'(h0.hdr_valid), 64'd0);
    ari = 1'b0;

    // 4DW MWr len=2: exact payload, then one DW too many
    set4(32'h6000_0002, 32'h0123_0A0F, 32'h0000_0001, 32'h2000_0000);
    tlp[4] = 32'hAAAA_0001; tlp[5] = 32'hAAAA_0002; tlp[6] = 32'hAAAA_0003;
    for (int i = 0; i < 3; i++) put_dw(tlp[i], i == 0, 1'b0);
    expect_rec(tlp[0], tlp[1], tlp[2], tlp[3]);
    put_dw(tlp[3], 1'b0, 1'b0);
    chk("mwr_addr", h0.hdr_addr, 64'h1_2000_0000);
    chk("mwr_is4", 64'(h0.hdr_is_4dw), 64'd1);
    put_dw(tlp[4], 1'b0, 1'b0);
    put_dw(tlp[5], 1'b0, 1'b1);
    idle(3);
    chk_errs("mwr_exact");
    send_tlp(7);
    idle(3);
    chk_errs("mwr_long");

    // T9 set: 8-bit instance flags, 10-bit instance keeps the full tag
    m = model_rec(32'h0080_0001, 32'h0123_0A0F, 32'h1000_0004, 32'h0, 1'b0, 1'b1);
    chk("model_tag10", 64'(m.tag), 64'h20A);
    set4(32'h0080_0001, 32'h0123_0A0F, 32'h1000_0004, 32'h0);
    send_tlp(3);
    chk("tag8_err", 64'(h0.err_tag), 64'd1);
    chk("tag8_val", 64'(h0.hdr_tag), 64'h00A);
    chk("tag10_err", 64'(h1.err_tag), 64'd0);
    chk("tag10_val", 64'(h1.hdr_tag), 64'h20A);
    idle(3);

    // Truncated header: eop on DW1
    put_dw(32'h0000_0001, 1'b1, 1'b0);
    put_dw(32'h0123_0A0F, 1'b0, 1'b1);
    exp_mal++;
    idle(3);
    chk("trunc_no_valid", 64'(h0.hdr_valid), 64'd0);
    chk_errs("trunc");

    // New sop while waiting for DW2 aborts, the new TLP decodes
    put_dw(32'h0000_0001, 1'b1, 1'b0);
    put_dw(32'h0123_0A0F, 1'b0, 1'b0);
    exp_mal++;
    set4(32'h0000_0002, 32'hAB12_3456, 32'hDEAD_BEEF, 32'h0);
    send_tlp(3);
    chk("abort_addr", h0.hdr_addr, 64'hDEAD_BEEC);
    idle(3);
    chk_errs("abort");

    // TLP prefix is malformed and drained silently
    put_dw(32'h8000_0000, 1'b1, 1'b0);
    put_dw(32'h1111_1111, 1'b0, 1'b0);
    put_dw(32'h2222_2222, 1'b0, 1'b1);
    exp_mal++;
    idle(3);
    chk_errs("prefix");

    // No-payload header followed by an extra DW; payload TLP cut at the header
    set4(32'h0000_0001, 32'h0123_0A0F, 32'h1000_0004, 32'h5555_5555);
    send_tlp(4);
    idle(3);
    chk_errs("mrd_extra");
    set4(32'h4000_0001, 32'h0123_0A0F, 32'h1000_0004, 32'h0);
    send_tlp(3);
    idle(3);
    chk_errs("mwr_short");

    // Length 0 means 1024 payload DWs
    set4(32'h6000_0000, 32'h0000_00FF, 32'h0000_0000, 32'h0000_0010);
    for (int i = 4; i < 1028; i++) tlp[i] = 32'(i);
    send_tlp(1028);
    idle(3);
    chk_errs("len1024");

    // Reset mid-drain, stray DWs, then a clean TLP
    set4(32'h6000_0004, 32'h0123_0A0F, 32'h0000_0001, 32'h2000_0000);
    expect_rec(tlp[0], tlp[1], tlp[2], tlp[3]);
    for (int i = 0; i < 4; i++) put_dw(tlp[i], i == 0, 1'b0);
    put_dw(32'hBBBB_0001, 1'b0, 1'b0);
    put_dw(32'hBBBB_0002, 1'b0, 1'b0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 64'(s0.in_ready), 64'd0);
    @(posedge clk); #3;
    rst = 1'b1;
    put_dw(32'hCCCC_0001, 1'b0, 1'b0);
    put_dw(32'hCCCC_0002, 1'b0, 1'b1);
    idle(2);
    chk("stray_no_valid", 64'(h0.hdr_valid), 64'd0);
    set4(32'h0000_0001, 32'h0123_0A0F, 32'h1000_0004, 32'h0);
    send_tlp(3);
    chk("post_rst_valid", 64'(h0.hdr_valid), 64'd1);
    chk("post_rst_addr", h0.hdr_addr, 64'h1000_0004);
    idle(3);
    chk_errs("post_rst");
    chk("records_drained", 64'(q0.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
